lane_deskew: RTL and testbench

LANE_DESKEW -- requirements
Module: lane_deskew

---
 rtl/usb4_deskew_pkg.sv | 12 +
 rtl/lane_deskew_if.sv | 22 ++
 rtl/deskew_lane_buffer.sv | 61 ++++++
 rtl/lane_deskew.sv | 99 +++++++++
 tb/tb_lane_deskew.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/usb4_deskew_pkg.sv
// Shared types and defaults for the two-lane deskew block.
package usb4_deskew_pkg;
  localparam int         DEF_DEPTH  = 8;
  localparam logic [7:0] DEF_MARKER = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2,
    ERROR  = 2'd3
  } dsk_state_t;
endpackage

// File: rtl/lane_deskew_if.sv
// Byte-lane bundle between the decoder and the deskew stage.
interface lane_deskew_if;
  logic       enable_deskew;
  logic [7:0] lane_0_rx;
  logic [7:0] lane_1_rx;
  logic       data_os;
  logic [7:0] lane_0_out;
  logic [7:0] lane_1_out;
  logic       data_os_out;
  logic       out_valid;
  logic       deskew_done;
  logic       deskew_err;

  modport master (
    output enable_deskew, lane_0_rx, lane_1_rx, data_os,
    input  lane_0_out, lane_1_out, data_os_out, out_valid, deskew_done, deskew_err
  );
  modport slave (
    input  enable_deskew, lane_0_rx, lane_1_rx, data_os,
    output lane_0_out, lane_1_out, data_os_out, out_valid, deskew_done, deskew_err
  );
endinterface

// File: rtl/deskew_lane_buffer.sv
// One lane's circular skew buffer: write pointer, marker detect with
// latched marker slot, and a read pointer that starts at that slot.
// A read of the slot being written this cycle bypasses to the input, so
// the later lane of a pair sees one cycle of latency.
module deskew_lane_buffer import usb4_deskew_pkg::*; #(
  parameter int         DEPTH  = DEF_DEPTH,
  parameter logic [7:0] MARKER = DEF_MARKER,
  parameter int         W      = 9
) (
  input  logic         enc_clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         os_in,
  input  logic         srch_en,
  input  logic         clr_found,
  input  logic         rd_start,
  input  logic         rd_adv,
  output logic         hit,
  output logic         found,
  output logic [W-1:0] rd_word
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr, pos, rd_addr;

  assign hit     = srch_en && !found && !os_in && (din[7:0] == MARKER);
  assign rd_addr = rd_start ? (found ? pos : wptr) : rptr;
  assign rd_word = (rd_addr == wptr) ? din : mem[rd_addr];

  // skew storage, written every enabled cycle
  always_ff @(posedge enc_clk)
    if (wr_en) mem[wptr] <= din;

  // write/read pointers; pointer arithmetic wraps modulo DEPTH
  always_ff @(posedge enc_clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (!wr_en) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + 1'b1;
      if (rd_adv) rptr <= rd_addr + 1'b1;
    end

  // first marker of a search latches its slot; later ones are ignored
  always_ff @(posedge enc_clk or negedge rst)
    if (!rst) begin
      found <= 1'b0;
      pos   <= '0;
    end else if (clr_found) begin
      found <= 1'b0;
      pos   <= '0;
    end else if (hit) begin
      found <= 1'b1;
      pos   <= wptr;
    end
endmodule

// File: rtl/lane_deskew.sv
// Two-lane deskew: finds MARKER on each lane, measures the skew and
// replays both lanes aligned from the marker onward.
// Optional: DESKEW_RELOCK_CHECK_EN flags a marker read out on only one
// lane while locked and drops back to search.
module lane_deskew import usb4_deskew_pkg::*; #(
  parameter int         DEPTH  = DEF_DEPTH,
  parameter logic [7:0] MARKER = DEF_MARKER
) (
  input logic         enc_clk,
  input logic         rst,
  lane_deskew_if.slave bus
);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW-1:0] CNT_MAX = PW'(DEPTH - 2);

  dsk_state_t    state, nxt;
  logic          en, hit0, hit1, f0, f1;
  logic          lock_go, rd_adv, clr_found, srch_en, relock_bad;
  logic [8:0]    w0;
  logic [7:0]    w1;
  logic [PW-1:0] cnt;

  assign en      = bus.enable_deskew;
  assign srch_en = (state == SEARCH);

  deskew_lane_buffer #(.DEPTH(DEPTH), .MARKER(MARKER), .W(9)) u_lane0 (
    .enc_clk(enc_clk), .rst(rst), .wr_en(en),
    .din({bus.data_os, bus.lane_0_rx}), .os_in(bus.data_os),
    .srch_en(srch_en), .clr_found(clr_found), .rd_start(lock_go), .rd_adv(rd_adv),
    .hit(hit0), .found(f0), .rd_word(w0)
  );

  deskew_lane_buffer #(.DEPTH(DEPTH), .MARKER(MARKER), .W(8)) u_lane1 (
    .enc_clk(enc_clk), .rst(rst), .wr_en(en),
    .din(bus.lane_1_rx), .os_in(bus.data_os),
    .srch_en(srch_en), .clr_found(clr_found), .rd_start(lock_go), .rd_adv(rd_adv),
    .hit(hit1), .found(f1), .rd_word(w1)
  );

`ifdef DESKEW_RELOCK_CHECK_EN
  assign relock_bad = bus.out_valid && !bus.data_os_out &&
                      ((bus.lane_0_out == MARKER) != (bus.lane_1_out == MARKER));
`else
  assign relock_bad = 1'b0;
`endif

  // state register
  always_ff @(posedge enc_clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nxt;

  // next state; dropping enable always returns to idle
  always_comb begin
    nxt = state;
    if (!en) nxt = IDLE;
    else begin
      case (state)
        IDLE:    nxt = SEARCH;
        SEARCH:  if ((f0 || hit0) && (f1 || hit1))  nxt = LOCKED;
                 else if ((f0 ^ f1) && cnt == CNT_MAX) nxt = ERROR;
        LOCKED:  if (relock_bad) nxt = ERROR;
        ERROR:   nxt = SEARCH;
        default: nxt = IDLE;
      endcase
    end
  end

  // state-derived controls and status
  always_comb begin
    lock_go         = (state == SEARCH) && (nxt == LOCKED);
    rd_adv          = lock_go || ((state == LOCKED) && (nxt == LOCKED));
    clr_found       = !en || (state == ERROR);
    bus.deskew_done = (state == LOCKED);
    bus.deskew_err  = (state == ERROR);
  end

  // skew counter: starts at first found lane, counts until the other shows
  always_ff @(posedge enc_clk or negedge rst)
    if (!rst)                               cnt <= '0;
    else if (!en || state != SEARCH)        cnt <= '0;
    else if (!f0 && !f1 && (hit0 ^ hit1))   cnt <= PW'(1);
    else if (f0 ^ f1)                       cnt <= cnt + 1'b1;

  // aligned output register; bytes hold when not advancing
  always_ff @(posedge enc_clk or negedge rst)
    if (!rst) begin
      bus.lane_0_out  <= '0;
      bus.lane_1_out  <= '0;
      bus.data_os_out <= 1'b0;
      bus.out_valid   <= 1'b0;
    end else begin
      bus.out_valid <= rd_adv;
      if (rd_adv) begin
        bus.lane_0_out  <= w0[7:0];
        bus.lane_1_out  <= w1;
        bus.data_os_out <= w0[8];
      end
    end
endmodule

// File: tb/tb_lane_deskew.sv
// Scoreboard bench for lane_deskew (DEPTH=8, MARKER=F0).
module tb_lane_deskew;
  localparam int DEPTH = 8;
`ifdef DESKEW_RELOCK_CHECK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  logic enc_clk = 1'b0;
  logic rst     = 1'b1;

  lane_deskew_if bus();

  lane_deskew #(.DEPTH(DEPTH), .MARKER(8'hF0)) dut (
    .enc_clk(enc_clk), .rst(rst), .bus(bus)
  );

  always #5 enc_clk = ~enc_clk;

  typedef struct packed {
    logic [7:0] l0;
    logic [7:0] l1;
    logic       os;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Stream construction: lane 0 carries 10+c, with F0 at cycles m and e;
  // lane 1 carries the same stream delayed by s, filler 01 before it.
  function automatic logic [7:0] b0(input int c, input int m, input int e);
    return (c == m || c == e) ? 8'hF0 : 8'(16 + c);
  endfunction
  function automatic logic [7:0] b1(input int c, input int m, input int s);
    if (c < s) return 8'h01;
    return (c - s == m) ? 8'hF0 : 8'(16 + c - s);
  endfunction
  function automatic logic osf(input int c, input int m, input int s, input int e);
    return !(c == m || c == e || (c >= s && c - s == m));
  endfunction

  // expected aligned pairs from the lane-0 marker onward
  task automatic push_exp(input int m, input int s, input int e, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      int j;
      j = m + k;
      q.push_back('{l0: b0(j, m, e), l1: b1(j + s, m, s), os: osf(j, m, s, e)});
    end
  endtask

  task automatic drive(input int n, input int m, input int s, input int e);
    bit locked;
    int t, stop, errc;
    locked = (m >= 0) && (s <= DEPTH - 2);
    t      = m + s;
    stop   = (RELOCK && locked && e >= 0) ? e + s + 2 : 32'h4000_0000;
    errc   = (m >= 0 && !locked) ? m + DEPTH - 1 :
             ((stop != 32'h4000_0000) ? stop : -1);
    for (int c = 0; c < n; c++) begin
      @(posedge enc_clk); #1;
      bus.enable_deskew = 1'b1;
      bus.lane_0_rx     = b0(c, m, e);
      bus.lane_1_rx     = b1(c, m, s);
      bus.data_os       = osf(c, m, s, e);
      @(negedge enc_clk);
      chk("deskew_done", bus.deskew_done, locked && c > t && c < stop);
      chk("deskew_err",  bus.deskew_err,  c == errc);
      chk("out_valid",   bus.out_valid,   locked && c > t && c < stop);
    end
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      @(posedge enc_clk); #1;
      bus.enable_deskew = 1'b0;
      @(negedge enc_clk);
      if (c > 0) begin
        chk("idle_out_valid",   bus.out_valid,   0);
        chk("idle_deskew_done", bus.deskew_done, 0);
      end
    end
  endtask

  task automatic drained(input string name);
    chk(name, q.size(), 0);
    q.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_lane_0_out",  bus.lane_0_out,  0);
    chk("rst_lane_1_out",  bus.lane_1_out,  0);
    chk("rst_data_os_out", bus.data_os_out, 0);
    chk("rst_out_valid",   bus.out_valid,   0);
    chk("rst_deskew_done", bus.deskew_done, 0);
    chk("rst_deskew_err",  bus.deskew_err,  0);
  endtask

  // monitor: every valid output must match the next expected pair
  always @(negedge enc_clk) begin
    if (rst && bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: actual %h/%h required none at %0t",
                 bus.lane_0_out, bus.lane_1_out, $time);
      end else begin
        mon_e = q.pop_front();
        chk("lane_0_out",  bus.lane_0_out,  mon_e.l0);
        chk("lane_1_out",  bus.lane_1_out,  mon_e.l1);
        chk("data_os_out", bus.data_os_out, mon_e.os);
      end
    end
  end

  initial begin
    bus.enable_deskew = 1'b0;
    bus.lane_0_rx     = 8'h00;
    bus.lane_1_rx     = 8'h00;
    bus.data_os       = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge enc_clk);
    chk_reset_vals();
    #1 rst = 1'b1;

    // lane 1 three cycles late, marker at byte 5
    push_exp(5, 3, -1, 12);
    drive(20, 5, 3, -1);
    idle(2);
    drained("skew3_drained");

    // re-enable after a drop with skew 2
    push_exp(4, 2, -1, 8);
    drive(14, 4, 2, -1);
    idle(2);
    drained("skew2_drained");

    // aligned lanes, markers in the same cycle
    push_exp(3, 0, -1, 7);
    drive(10, 3, 0, -1);
    idle(2);
    drained("skew0_drained");

    // markers straddle the pointer wrap: lane 0 slot 7, lane 1 slot 1
    push_exp(7, 2, -1, 7);
    drive(16, 7, 2, -1);
    idle(2);
    drained("wrap_drained");

    // lane 1 never marks: one error pulse, then search resumes and locks
    drive(14, 3, 100, -1);
    push_exp(2, 0, -1, 6);
    drive(8, 2, 0, -1);
    idle(2);
    drained("err_relock_drained");

    // lone marker on lane 0 while locked
    push_exp(2, 0, 6, RELOCK ? 5 : 10);
    drive(12, 2, 0, 6);
    idle(2);
    drained("lone_marker_drained");

    // reset in the middle of a lock: immediate clear, nothing replayed
    push_exp(2, 1, -1, 4);
    drive(8, 2, 1, -1);
    #2 rst = 1'b0;
    bus.enable_deskew = 1'b0;
    #1 chk_reset_vals();
    @(negedge enc_clk);
    #1 rst = 1'b1;
    drive(6, -1, 100, -1);
    idle(2);
    drained("reset_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
